// File: rtl/uart_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_mem_responder_pkg                                               |
// | Opcodes, default response bytes and FSM state encoding shared by the |
// | UART memory responder.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_mem_responder_pkg;

  localparam logic [7:0] OP_READ      = 8'h00;
  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] ACK_BYTE_DEF = 8'h01;
  localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_ADDR = 4'd1,
    S_GET_DHI  = 4'd2,
    S_GET_DLO  = 4'd3,
    S_SEND_HI  = 4'd4,
    S_WAIT_HI  = 4'd5,
    S_SEND_LO  = 4'd6,
    S_WAIT_LO  = 4'd7,
    S_SEND_1   = 4'd8,
    S_WAIT_1   = 4'd9
  } state_e;

  // Command-collection states: the only states where the idle timeout runs.
  function automatic logic is_get_state(input state_e s);
    return (s == S_GET_ADDR) || (s == S_GET_DHI) || (s == S_GET_DLO);
  endfunction

  // Response states: a byte arriving here cannot be serviced.
  function automatic logic is_tx_state(input state_e s);
    return (s != S_IDLE) && !is_get_state(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_mem_responder_if                                                |
// | Byte-level link between a UART core and the memory responder.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_mem_responder_if;

  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       busy;
  logic       overrun;

  // UART side: delivers received bytes and transmit completion.
  modport master (
    output rx_done, rx_data, tx_done,
    input  tx_en, tx_data, busy, overrun
  );

  // Responder side.
  modport slave (
    input  rx_done, rx_data, tx_done,
    output tx_en, tx_data, busy, overrun
  );

endinterface
`default_nettype wire

// File: rtl/uart_mem_responder_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_256x16                                                           |
// | Word memory with synchronous write and combinational read; kept in   |
// | its own module so it can be replaced by an SRAM macro.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_256x16 #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/uart_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_mem_responder                                                   |
// | Serves READ/WRITE commands received as UART bytes against a word     |
// | memory; reads answer high then low byte, writes answer with an ACK.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_mem_responder
  import uart_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  uart_mem_responder_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dhi_q, dhi_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              timed_out;

  mem_256x16 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i ({dhi_q, bus.rx_data}),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign timed_out = (cnt_q == CNT_LAST) && !bus.rx_done;

  // Next-state, datapath loads and memory control.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dhi_d     = dhi_q;
    is_wr_d   = is_wr_q;
    tx_data_d = tx_data_q;
    overrun_d = overrun_q;
    mem_we    = 1'b0;
    rd_addr   = addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_done) begin
          if ((bus.rx_data == OP_READ) || (bus.rx_data == OP_WRITE)) begin
            is_wr_d = (bus.rx_data == OP_WRITE);
            state_d = S_GET_ADDR;
          end else begin
            tx_data_d = ERR_BYTE;
            state_d   = S_SEND_1;
          end
        end
      end
      S_GET_ADDR: begin
        // Read through the incoming address so the high byte is ready
        // for the very next cycle.
        rd_addr = ADDR_W'(bus.rx_data);
        if (bus.rx_done) begin
          addr_d = ADDR_W'(bus.rx_data);
          if (is_wr_q) begin
            state_d = S_GET_DHI;
          end else begin
            tx_data_d = rd_data[15:8];
            state_d   = S_SEND_HI;
          end
        end else if (timed_out) begin
          state_d = S_IDLE;
        end
      end
      S_GET_DHI: begin
        if (bus.rx_done) begin
          dhi_d   = bus.rx_data;
          state_d = S_GET_DLO;
        end else if (timed_out) begin
          state_d = S_IDLE;
        end
      end
      S_GET_DLO: begin
        if (bus.rx_done) begin
          mem_we    = 1'b1;
          tx_data_d = ACK_BYTE;
          state_d   = S_SEND_1;
        end else if (timed_out) begin
          state_d = S_IDLE;
        end
      end
      S_SEND_HI: state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (bus.tx_done) begin
          tx_data_d = rd_data[7:0];
          state_d   = S_SEND_LO;
        end
      end
      S_SEND_LO: state_d = S_WAIT_LO;
      S_WAIT_LO: if (bus.tx_done) state_d = S_IDLE;
      S_SEND_1:  state_d = S_WAIT_1;
      S_WAIT_1:  if (bus.tx_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Bytes arriving while a response is in flight are dropped.
    if (bus.rx_done && is_tx_state(state_q)) begin
      overrun_d = 1'b1;
    end
  end

  // Inter-byte idle counter: restarts on every byte and on each state change.
  always_comb begin
    cnt_d = '0;
    if (is_get_state(state_q) && !bus.rx_done && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      dhi_q     <= '0;
      is_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dhi_q     <= dhi_d;
      is_wr_q   <= is_wr_d;
      tx_data_q <= tx_data_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.tx_en   = (state_q == S_SEND_HI) || (state_q == S_SEND_LO) ||
                       (state_q == S_SEND_1);
  assign bus.tx_data = tx_data_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.overrun = overrun_q;

endmodule
`default_nettype wire
